// File: rtl/rom_bus_pkg.sv
// Shared constants and state encoding for the parallel ROM bus initiator and its ROM model.
package rom_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RECOVER = 2'd2
    } rom_state_e;

    localparam int ROM_WIDTH       = 16;
    localparam int DEF_ADDR_BITS   = 12;
    localparam int DEF_BEATS       = 2;
    localparam int DEF_WAIT_CYCLES = 7;
    localparam int DEF_RECOVER     = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rom_access_timer.sv
// Down-counter shared by the ACCESS and RECOVER windows; o_done is high in the last cycle of a window.
module rom_access_timer #(
    parameter int CNT_BITS = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_load,
    input  logic [CNT_BITS-1:0] i_load_val,
    input  logic                i_clear,
    output logic                o_done
);

    logic [CNT_BITS-1:0] r_count;
    logic                r_active;

    // Count state: load has priority, then clear, then count down to zero and stop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= {CNT_BITS{1'b0}};
            r_active <= 1'b0;
        end else if (i_load) begin
            r_count  <= i_load_val;
            r_active <= 1'b1;
        end else if (i_clear) begin
            r_count  <= {CNT_BITS{1'b0}};
            r_active <= 1'b0;
        end else if (r_active) begin
            if (r_count == {CNT_BITS{1'b0}}) begin
                r_active <= 1'b0;
            end else begin
                r_count <= r_count - {{(CNT_BITS-1){1'b0}}, 1'b1};
            end
        end else begin
            r_count  <= r_count;
            r_active <= r_active;
        end
    end

    assign o_done = r_active && (r_count == {CNT_BITS{1'b0}});

endmodule

// File: rtl/rom_fetch_ctrl.sv
// ROM fetch initiator: drives CE/OE/PCadr, samples one or two beats and returns an assembled instruction.
module rom_fetch_ctrl
    import rom_bus_pkg::*;
#(
    parameter int WIDTH       = ROM_WIDTH,
    parameter int ADDR_BITS   = DEF_ADDR_BITS,
    parameter int BEATS       = DEF_BEATS,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int RECOVER     = DEF_RECOVER
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic [ADDR_BITS-1:0]     req_addr,
    output logic                     req_ready,
    input  logic                     flush,
    output logic                     rsp_valid,
    output logic [WIDTH*BEATS-1:0]   instr,
    output logic                     CE,
    output logic                     OE,
    output logic [ADDR_BITS-1:0]     PCadr,
    input  logic [WIDTH-1:0]         rom_data
);

    localparam int                  TMR_BITS     = $clog2(max_int(WAIT_CYCLES, RECOVER) + 1);
    localparam logic [TMR_BITS-1:0] ACCESS_LOAD  = TMR_BITS'(WAIT_CYCLES - 1);
    localparam logic [TMR_BITS-1:0] RECOVER_LOAD = TMR_BITS'(RECOVER - 1);
    localparam logic                BEAT_LAST    = 1'(BEATS - 1);

    rom_state_e                 r_state, w_state_nxt;
    logic                       r_ce_n, w_ce_n_nxt;
    logic [ADDR_BITS-1:0]       r_pcadr, w_pcadr_nxt;
    logic [ADDR_BITS-1:0]       r_base, w_base_nxt;
    logic                       r_beat, w_beat_nxt;
    logic [WIDTH*BEATS-1:0]     r_asm, w_asm_nxt, w_asm_cap;
    logic [WIDTH*BEATS-1:0]     r_instr, w_instr_nxt;
    logic                       r_rsp, w_rsp_nxt;
    logic                       r_ready, w_ready_nxt;
    logic                       r_abort, w_abort_nxt;
    logic                       w_tmr_load, w_tmr_clear, w_tmr_done;
    logic [TMR_BITS-1:0]        w_tmr_val;
    logic                       w_beat_inc;

    rom_access_timer #(.CNT_BITS(TMR_BITS)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_clear    (w_tmr_clear),
        .o_done     (w_tmr_done)
    );

    assign w_beat_inc = r_beat + 1'b1;

    // Merge the ROM word into the lane selected by the current beat.
    always_comb begin
        w_asm_cap = r_asm;
        for (int b = 0; b < BEATS; b++) begin
            if (r_beat == 1'(b)) begin
                w_asm_cap[b*WIDTH +: WIDTH] = rom_data;
            end else begin
                w_asm_cap[b*WIDTH +: WIDTH] = r_asm[b*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and next-output logic; a flush latches r_abort so no further beat or response follows.
    always_comb begin
        w_state_nxt = r_state;
        w_ce_n_nxt  = r_ce_n;
        w_pcadr_nxt = r_pcadr;
        w_base_nxt  = r_base;
        w_beat_nxt  = r_beat;
        w_asm_nxt   = r_asm;
        w_instr_nxt = r_instr;
        w_rsp_nxt   = 1'b0;
        w_ready_nxt = r_ready;
        w_abort_nxt = r_abort;
        w_tmr_load  = 1'b0;
        w_tmr_clear = 1'b0;
        w_tmr_val   = ACCESS_LOAD;
        case (r_state)
            ST_IDLE: begin
                if (req_valid && r_ready && !flush) begin
                    w_base_nxt  = req_addr;
                    w_pcadr_nxt = req_addr;
                    w_ce_n_nxt  = 1'b0;
                    w_beat_nxt  = 1'b0;
                    w_ready_nxt = 1'b0;
                    w_abort_nxt = 1'b0;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = ACCESS_LOAD;
                    w_state_nxt = ST_ACCESS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (flush) begin
                    w_ce_n_nxt  = 1'b1;
                    w_abort_nxt = 1'b1;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = RECOVER_LOAD;
                    w_state_nxt = ST_RECOVER;
                end else if (w_tmr_done) begin
                    w_ce_n_nxt  = 1'b1;
                    w_asm_nxt   = w_asm_cap;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = RECOVER_LOAD;
                    w_state_nxt = ST_RECOVER;
                    if (r_beat == BEAT_LAST) begin
                        w_instr_nxt = w_asm_cap;
                        w_rsp_nxt   = 1'b1;
                    end else begin
                        w_instr_nxt = r_instr;
                    end
                end else begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_RECOVER: begin
                if (flush) begin
                    w_abort_nxt = 1'b1;
                end else begin
                    w_abort_nxt = r_abort;
                end
                if (w_tmr_done) begin
                    if (!r_abort && !flush && (r_beat != BEAT_LAST)) begin
                        w_beat_nxt  = w_beat_inc;
                        w_pcadr_nxt = r_base + ADDR_BITS'(w_beat_inc);
                        w_ce_n_nxt  = 1'b0;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = ACCESS_LOAD;
                        w_state_nxt = ST_ACCESS;
                    end else begin
                        w_ready_nxt = 1'b1;
                        w_tmr_clear = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_RECOVER;
                end
            end
            default: begin
                w_ce_n_nxt  = 1'b1;
                w_ready_nxt = 1'b1;
                w_tmr_clear = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Register state and every bus-facing output; reset drops the ROM strobes immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ce_n  <= 1'b1;
            r_pcadr <= {ADDR_BITS{1'b0}};
            r_base  <= {ADDR_BITS{1'b0}};
            r_beat  <= 1'b0;
            r_asm   <= {(WIDTH*BEATS){1'b0}};
            r_instr <= {(WIDTH*BEATS){1'b0}};
            r_rsp   <= 1'b0;
            r_ready <= 1'b1;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ce_n  <= w_ce_n_nxt;
            r_pcadr <= w_pcadr_nxt;
            r_base  <= w_base_nxt;
            r_beat  <= w_beat_nxt;
            r_asm   <= w_asm_nxt;
            r_instr <= w_instr_nxt;
            r_rsp   <= w_rsp_nxt;
            r_ready <= w_ready_nxt;
            r_abort <= w_abort_nxt;
        end
    end

    assign CE        = r_ce_n;
    assign OE        = r_ce_n;
    assign PCadr     = r_pcadr;
    assign instr     = r_instr;
    assign rsp_valid = r_rsp;
    assign req_ready = r_ready;

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Bench for rom_fetch_ctrl with an inline ROM model holding data[a] = 16'hA000 + a.
module tb_rom_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [11:0] req_addr;
    logic        req_ready;
    logic        flush;
    logic        rsp_valid;
    logic [31:0] instr;
    logic        CE;
    logic        OE;
    logic [11:0] PCadr;
    logic [15:0] rom_data;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_instr = 32'd0;
    logic [3:0]  rom_cnt = 4'd0;

    rom_fetch_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .instr     (instr),
        .CE        (CE),
        .OE        (OE),
        .PCadr     (PCadr),
        .rom_data  (rom_data)
    );

    always #5 clk = ~clk;

    // ROM: data appears only after the 6th edge with CE/OE low; high CE clears the access count.
    always @(posedge clk) begin
        if (CE !== 1'b0) rom_cnt <= 4'd0;
        else if (rom_cnt != 4'd15) rom_cnt <= rom_cnt + 4'd1;
    end
    assign rom_data = (CE === 1'b0 && OE === 1'b0 && rom_cnt >= 4'd6) ? (16'hA000 + 16'(PCadr)) : 16'hBAD0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rom_pair(input logic [11:0] a);
        logic [11:0] a1;
        a1 = a + 12'd1;
        return {16'hA000 + 16'(a1), 16'hA000 + 16'(a)};
    endfunction

    // One fetch; k counts edges after the accept edge. flush_edge<=0 means no flush.
    task automatic run_fetch(input logic [11:0] addr, input int flush_edge,
                             input bit hold, input logic [11:0] next_addr);
        int          budget;
        bit          flushed;
        bit          ce_low;
        bit          exp_rsp;
        bit          exp_ready;
        logic [11:0] exp_pc;
        budget = 0;
        while (req_ready !== 1'b1 && budget < 40) begin
            tick();
            budget++;
        end
        check("ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        flush     = 1'b0;
        tick();
        if (hold) req_addr = next_addr;
        else      req_valid = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            flushed   = (flush_edge > 0) && (k >= flush_edge);
            ce_low    = !flushed && (k < 15) && ((k % 8) != 7);
            exp_rsp   = (flush_edge <= 0) && (k == 15);
            exp_ready = (flush_edge > 0) ? (k >= flush_edge + 1) : (k >= 16);
            exp_pc    = (k < 8) ? addr : (addr + 12'd1);
            if (exp_rsp) last_instr = rom_pair(addr);
            check("ce",        32'(CE),        32'(!ce_low));
            check("oe",        32'(OE),        32'(!ce_low));
            check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("instr",     instr,          last_instr);
            if (ce_low) check("pcadr", 32'(PCadr), 32'(exp_pc));
            if (k < 16) begin
                if (k + 1 == flush_edge) flush = 1'b1;
                tick();
                flush = 1'b0;
            end
        end
    endtask

    initial begin
        int fe;
        logic [11:0] ra;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = 12'd0;
        flush     = 1'b0;
        repeat (3) tick();
        check("rst_ce",    32'(CE),        32'd1);
        check("rst_oe",    32'(OE),        32'd1);
        check("rst_pc",    32'(PCadr),     32'd0);
        check("rst_instr", instr,          32'd0);
        check("rst_rsp",   32'(rsp_valid), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        reset = 1'b0;
        tick();

        run_fetch(12'h010, 0, 1'b0, 12'h000);
        run_fetch(12'hFFF, 0, 1'b0, 12'h000);
        run_fetch(12'h055, 3, 1'b0, 12'h000);
        run_fetch(12'h020, 0, 1'b0, 12'h000);
        run_fetch(12'h077, 15, 1'b0, 12'h000);

        // Flush in IDLE together with a request: nothing is accepted.
        req_valid = 1'b1;
        req_addr  = 12'h123;
        flush     = 1'b1;
        tick();
        req_valid = 1'b0;
        flush     = 1'b0;
        check("idle_flush_ce",    32'(CE),        32'd1);
        check("idle_flush_ready", 32'(req_ready), 32'd1);

        // Reset in the middle of beat 1 acts without a clock edge.
        req_valid = 1'b1;
        req_addr  = 12'h3A0;
        tick();
        req_valid = 1'b0;
        repeat (9) tick();
        check("mid_ce_low", 32'(CE), 32'd0);
        #1 reset = 1'b1;
        #1;
        check("async_ce",    32'(CE),        32'd1);
        check("async_oe",    32'(OE),        32'd1);
        check("async_rsp",   32'(rsp_valid), 32'd0);
        check("async_ready", 32'(req_ready), 32'd1);
        check("async_pc",    32'(PCadr),     32'd0);
        check("async_instr", instr,          32'd0);
        last_instr = 32'd0;
        tick();
        reset = 1'b0;
        tick();
        run_fetch(12'h3A0, 0, 1'b0, 12'h000);

        // Back-to-back with req_valid held high across the busy window.
        run_fetch(12'h100, 0, 1'b1, 12'h102);
        run_fetch(12'h102, 0, 1'b0, 12'h000);

        for (int i = 0; i < 8; i++) begin
            ra = 12'($urandom_range(0, 4095));
            fe = 0;
            if ($urandom_range(0, 2) == 0) begin
                fe = int'($urandom_range(1, 14));
                if (fe >= 8) fe = fe + 1;
            end
            run_fetch(ra, fe, 1'b0, 12'h000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
